// File: rtl/led_shift_if.sv
// led_shift_if: control inputs and registered LED outputs of the chaser
interface led_shift_if #(
  parameter int LED_W = 4,
  parameter int DIV_W = 28
);
  localparam int POS_W = $clog2(LED_W);
  logic             en;
  logic [1:0]       mode;
  logic [DIV_W-1:0] div;
  logic             load;
  logic [POS_W-1:0] load_val;
  logic [LED_W-1:0] led_out;
  logic [POS_W-1:0] pos;
  logic             step;
  logic             dir;
  modport master (output en, mode, div, load, load_val, input led_out, pos, step, dir);
  modport slave  (input en, mode, div, load, load_val, output led_out, pos, step, dir);
endinterface

// File: rtl/led_shift_seq.sv
// led_shift_seq: walking one-hot LED chaser with prescaler, rotate/bounce/hold modes and position load
module led_shift_seq #(
  parameter int LED_W = 4,
  parameter int DIV_W = 28
) (
  input logic        clk,
  input logic        rst,
  led_shift_if.slave bus
);
  localparam int POS_W = $clog2(LED_W);
  localparam logic [POS_W-1:0] LAST = POS_W'(LED_W - 1);
  localparam logic [POS_W:0] LED_N = (POS_W + 1)'(LED_W);
  localparam logic [1:0] M_LEFT = 2'b00, M_RIGHT = 2'b01, M_BOUNCE = 2'b10, M_HOLD = 2'b11;
  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d, clamp;
  logic [LED_W-1:0] led_q, led_d;
  logic             step_q, step_d;
  dir_t             dir_q, dir_d, fwd;
  logic             tick, turn, adv;
  always_comb begin
    tick = bus.en && cnt_q >= bus.div;
    clamp = {1'b0, bus.load_val} >= LED_N ? LAST : bus.load_val;
    turn = bus.mode == M_BOUNCE && (dir_q == UP ? pos_q == LAST : pos_q == '0);
    fwd = bus.mode == M_LEFT ? UP : bus.mode == M_RIGHT ? DOWN : turn ? (dir_q == UP ? DOWN : UP) : dir_q;
    // a load swallows any coincident tick
    adv = tick && bus.mode != M_HOLD && !bus.load;
    cnt_d = (bus.load || tick) ? '0 : bus.en ? cnt_q + 1'b1 : cnt_q;
    pos_d = bus.load ? clamp : !adv ? pos_q :
            fwd == UP ? (pos_q == LAST ? '0 : pos_q + 1'b1) : (pos_q == '0 ? LAST : pos_q - 1'b1);
    dir_d = adv ? fwd : dir_q;
    step_d = adv;
    led_d = LED_W'(1) << pos_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      pos_q  <= '0;
      led_q  <= LED_W'(1);
      step_q <= 1'b0;
      dir_q  <= UP;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      led_q  <= led_d;
      step_q <= step_d;
      dir_q  <= dir_d;
    end
  end
  assign bus.led_out = led_q;
  assign bus.pos     = pos_q;
  assign bus.step    = step_q;
  assign bus.dir     = dir_q;
endmodule
